// File: rtl/alu_exec_if.sv
// Bundles the execute stage's issue, result and flag signals.
// The stage itself connects through the slave modport; its driver uses master.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] alu_mux_A_out;
    logic [WIDTH-1:0] alu_mux_B_out;
    logic [2:0]       alu_op;
    logic [2:0]       in_rd;
    logic             in_we;
    logic             in_setflag;
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             flush;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_result;
    logic [2:0]       ex_rd;
    logic             ex_we;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output alu_mux_A_out, alu_mux_B_out, alu_op, in_rd, in_we, in_setflag,
        output in_valid, out_ready, flush,
        input  in_ready, ex_valid, ex_result, ex_rd, ex_we, flag_n, flag_z, flag_c
    );

    modport slave (
        input  alu_mux_A_out, alu_mux_B_out, alu_op, in_rd, in_we, in_setflag,
        input  in_valid, out_ready, flush,
        output in_ready, ex_valid, ex_result, ex_rd, ex_we, flag_n, flag_z, flag_c
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Single-entry ALU execute stage with valid/ready handshake, flush and N/Z/C flags.
// The result register is the only buffer; it is refilled in the same cycle it drains.
module alu_exec_stage #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    alu_exec_if.slave  bus
);
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_CMP   = 3'd2;
    localparam logic [2:0] OP_PASSB = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_OR    = 3'd5;
    localparam logic [2:0] OP_XOR   = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    logic             in_ready_s;
    logic             accept_s;
    logic             sub_s;
    logic [WIDTH-1:0] b_operand_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_carry_s;
    logic             next_we_s;

    logic             ex_valid_r;
    logic [WIDTH-1:0] ex_result_r;
    logic [2:0]       ex_rd_r;
    logic             ex_we_r;
    logic             flag_n_r;
    logic             flag_z_r;
    logic             flag_c_r;

    // Handshake: a held entry may be replaced when downstream takes it; flush blocks entry.
    always_comb begin
        in_ready_s = (!ex_valid_r || bus.out_ready) && !bus.flush;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Datapath: SUB/CMP share the adder as A + ~B + 1 so carry means A >= B unsigned.
    always_comb begin
        sub_s        = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_CMP);
        b_operand_s  = sub_s ? ~bus.alu_mux_B_out : bus.alu_mux_B_out;
        sum_s        = {1'b0, bus.alu_mux_A_out} + {1'b0, b_operand_s}
                     + {{WIDTH{1'b0}}, sub_s};
        alu_result_s = {WIDTH{1'b0}};
        alu_carry_s  = 1'b0;
        case (bus.alu_op)
            OP_ADD, OP_SUB, OP_CMP: begin
                alu_result_s = sum_s[WIDTH-1:0];
                alu_carry_s  = sum_s[WIDTH];
            end
            OP_PASSB: alu_result_s = bus.alu_mux_B_out;
            OP_AND:   alu_result_s = bus.alu_mux_A_out & bus.alu_mux_B_out;
            OP_OR:    alu_result_s = bus.alu_mux_A_out | bus.alu_mux_B_out;
            OP_XOR:   alu_result_s = bus.alu_mux_A_out ^ bus.alu_mux_B_out;
            OP_PASSA: alu_result_s = bus.alu_mux_A_out;
            default: begin
                alu_result_s = {WIDTH{1'b0}};
                alu_carry_s  = 1'b0;
            end
        endcase
        next_we_s = bus.in_we && (bus.alu_op != OP_CMP);
    end

    // Result register: load on accept, drain when taken, hold while stalled, kill on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_r  <= 1'b0;
            ex_result_r <= {WIDTH{1'b0}};
            ex_rd_r     <= 3'd0;
            ex_we_r     <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_r  <= 1'b0;
            ex_we_r     <= 1'b0;
        end else if (accept_s) begin
            ex_valid_r  <= 1'b1;
            ex_result_r <= alu_result_s;
            ex_rd_r     <= bus.in_rd;
            ex_we_r     <= next_we_s;
        end else if (bus.out_ready) begin
            ex_valid_r  <= 1'b0;
            ex_we_r     <= 1'b0;
        end else begin
            ex_valid_r  <= ex_valid_r;
            ex_we_r     <= ex_we_r;
        end
    end

    // Flags follow only accepted flag-setting instructions; accept is already false on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_n_r <= 1'b0;
            flag_z_r <= 1'b0;
            flag_c_r <= 1'b0;
        end else if (accept_s && bus.in_setflag) begin
            flag_n_r <= alu_result_s[WIDTH-1];
            flag_z_r <= is_zero(alu_result_s);
            flag_c_r <= alu_carry_s;
        end else begin
            flag_n_r <= flag_n_r;
            flag_z_r <= flag_z_r;
            flag_c_r <= flag_c_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.ex_valid  = ex_valid_r;
    assign bus.ex_result = ex_result_r;
    assign bus.ex_rd     = ex_rd_r;
    assign bus.ex_we     = ex_we_r;
    assign bus.flag_n    = flag_n_r;
    assign bus.flag_z    = flag_z_r;
    assign bus.flag_c    = flag_c_r;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: a back-to-back vector table plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_alu_exec_stage;
    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rd;
        logic        we;
        logic        sf;
        logic [15:0] res;
        logic        exp_we;
        logic        n;
        logic        z;
        logic        c;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    vec_t vecs [12];

    alu_exec_if #(.WIDTH(16)) bus ();

    alu_exec_stage #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] res,
                           input logic [2:0] rd, input logic we,
                           input logic n, input logic z, input logic c);
        chk({tag, " ex_valid"},  {31'd0, bus.ex_valid}, {31'd0, v});
        chk({tag, " ex_result"}, {16'd0, bus.ex_result}, {16'd0, res});
        chk({tag, " ex_rd"},     {29'd0, bus.ex_rd}, {29'd0, rd});
        chk({tag, " ex_we"},     {31'd0, bus.ex_we}, {31'd0, we});
        chk({tag, " flags"},     {29'd0, bus.flag_n, bus.flag_z, bus.flag_c}, {29'd0, n, z, c});
    endtask

    task automatic drive(input logic valid, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] rd,
                         input logic we, input logic sf);
        bus.in_valid      = valid;
        bus.alu_op        = op;
        bus.alu_mux_A_out = a;
        bus.alu_mux_B_out = b;
        bus.in_rd         = rd;
        bus.in_we         = we;
        bus.in_setflag    = sf;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //          op    a         b         rd    we    sf    res       exp_we n     z     c
        vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 3'd1, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 16'h0005, 16'h0005, 3'd2, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{3'd1, 16'h0000, 16'h0001, 3'd3, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 16'hFFFF, 16'h0001, 3'd4, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{3'd1, 16'h0008, 16'h0003, 3'd5, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'd4, 16'hF0F0, 16'h3C3C, 3'd6, 1'b1, 1'b1, 16'h3030, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'd5, 16'hF0F0, 16'h0F0F, 3'd7, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'd6, 16'hAAAA, 16'hAAAA, 3'd0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'd3, 16'h1234, 16'h8001, 3'd1, 1'b1, 1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd7, 16'h1234, 16'hFFFF, 3'd2, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 16'h0001, 16'h0001, 3'd3, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'd2, 16'h0003, 16'h0005, 3'd4, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, and ready is offered during reset
        reset = 1'b1;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back table: one accept per cycle with out_ready held high
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].we, vecs[i].sf);
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].res, vecs[i].rd, vecs[i].exp_we,
                    vecs[i].n, vecs[i].z, vecs[i].c);
        end

        // Drain with no new accept
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("drain ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("drain ex_we", {31'd0, bus.ex_we}, 32'd0);

        // Stall: SUB 0-1 held for 3 cycles while a new instruction waits
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'd1, 16'h0000, 16'h0001, 3'd5, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_out("stall load", 1'b1, 16'hFFFF, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'd0, 16'h0002, 16'h0002, 3'd6, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("stall hold%0d", k), 1'b1, 16'hFFFF, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            chk($sformatf("stall in_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
        end

        // Flush kills both the held SUB and the presented flag-setting ADD 0+0
        @(negedge clk);
        drive(1'b1, 3'd0, 16'h0000, 16'h0000, 3'd6, 1'b1, 1'b1);
        bus.flush = 1'b1;
        #1;
        chk("flush in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush ex_we", {31'd0, bus.ex_we}, 32'd0);
        chk("flush flags", {29'd0, bus.flag_n, bus.flag_z, bus.flag_c}, 32'b100);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        // Asynchronous reset mid-cycle while a live entry is held
        drive(1'b1, 3'd0, 16'h7FFF, 16'h0001, 3'd3, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_out("pre-reset", 1'b1, 16'h8000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        chk_out("async reset", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        // First accept on the first edge after reset deasserts
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 3'd0, 16'h0002, 16'h0003, 3'd7, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk_out("post-reset", 1'b1, 16'h0005, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter WIDTH, default 16, datapath width of operands, result and forwarding bus.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_mux_A_out  input  WIDTH  operand A from the operand-select stage.
REQ-005 alu_mux_B_out  input  WIDTH  operand B from the operand-select stage.
REQ-006 alu_op  input  3  0 ADD, 1 SUB, 2 CMP, 3 PASSB, 4 AND, 5 OR, 6 XOR, 7 PASSA.
REQ-007 in_rd  input  3  destination register index.
REQ-008 in_we  input  1  instruction writes register file.
REQ-009 in_setflag  input  1  instruction updates N/Z/C.
REQ-010 in_valid  input  1  upstream presents an instruction.
REQ-011 in_ready  output  1  stage accepts an instruction this cycle.
REQ-012 out_ready  input  1  downstream accepts the held result.
REQ-013 flush  input  1  kill held and incoming instruction (branch redirect).
REQ-014 ex_valid  output  1  result register holds a live instruction.
REQ-015 ex_result  output  WIDTH  registered ALU result.
REQ-016 ex_rd  output  3  registered destination index.
REQ-017 ex_we  output  1  registered write enable, already gated by ex_valid.
REQ-018 flag_n, flag_z, flag_c  output  1 each  architectural condition flags.

Function
REQ-019 in_ready SHALL equal (!ex_valid || out_ready) && !flush, combinationally.
REQ-020 Accept SHALL occur when in_valid && in_ready; on accept, result, rd and we SHALL be registered next edge and ex_valid SHALL be 1 (latency exactly 1 cycle).
REQ-021 When ex_valid && !out_ready, all ex_* outputs SHALL hold unchanged.
REQ-022 When ex_valid && out_ready && no accept, ex_valid SHALL drop to 0 next edge.
REQ-023 Accept and out_ready in the same cycle SHALL replace the held entry with no bubble.
REQ-024 flush SHALL clear ex_valid next edge, dropping both held and presented instruction; flags SHALL NOT update from the dropped instruction.
REQ-025 ADD: A+B mod 2^WIDTH; C = carry out of bit WIDTH-1.
REQ-026 SUB and CMP: A-B mod 2^WIDTH computed as A+~B+1; C = carry out (1 when A >= B unsigned).
REQ-027 CMP SHALL force registered ex_we to 0 regardless of in_we.
REQ-028 PASSB/PASSA output B/A; AND/OR/XOR bitwise; C SHALL be 0 for these ops.
REQ-029 N = result bit WIDTH-1; Z = (result == 0).
REQ-030 Flags SHALL update on the accept edge only when in_setflag=1; otherwise retain value.
REQ-031 ex_we SHALL be 0 whenever ex_valid is 0.
REQ-032 flag outputs SHALL be registered; a following instruction observes new flags one cycle after its producer is accepted.

Reset
REQ-033 reset asserted SHALL immediately force ex_valid=0, ex_we=0, ex_rd=0, ex_result=0, flag_n=0, flag_z=0, flag_c=0.
REQ-034 reset mid-stall SHALL discard the held instruction; first accept is allowed on the first edge after reset deasserts.
REQ-035 in_ready SHALL be 1 during reset when flush=0.

Verification
REQ-036 ADD A=0x7FFF, B=0x0001, setflag=1 -> next cycle ex_result=0x8000, N=1, Z=0, C=0, ex_valid=1.
REQ-037 CMP A=0x0005, B=0x0005, in_we=1 -> ex_result=0x0000, ex_we=0, Z=1, C=1, N=0.
REQ-038 SUB A=0x0000, B=0x0001 -> ex_result=0xFFFF, N=1, C=0; hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-039 Back-to-back ADDs with out_ready=1 -> ex_valid stays 1, one result per cycle, no bubble.
REQ-040 Stalled entry plus new in_valid with flush=1 -> ex_valid=0 next cycle, flags unchanged.
REQ-041 Assert reset asynchronously mid-cycle while ex_valid=1 -> ex_valid, ex_we, flags go 0 before next edge.
